// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   SZ_BYTE / SZ_HALF / SZ_WORD : access-size encodings carried on size_i
//                                 (2'b11 is reserved and always errors)
//   state_t                     : controller FSM states
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction and sign/zero extension (purely combinational).
//   i_word     : full 32-bit memory word (little-endian lanes)
//   i_lane     : byte address bits [1:0]
//   i_size     : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   o_data     : right-aligned, extended load result; 0 for reserved size
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    w_half = '0;
    o_data = '0;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Fixed-latency data-memory controller with byte/half/word loads and stores.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_i / ready_o     : request handshake; accepted when both high at an edge
//   we_i, size_i,
//   unsigned_i, addr_i,
//   wdata_i             : access descriptor, captured on accept
//   rvalid_o            : one-cycle completion pulse (RESP state)
//   rdata_o, err_o      : result registered on entry to RESP, held until the next
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_last_wait;
  logic              w_oob;
  logic              w_err;
  logic              w_commit;
  logic [3:0]        w_be;
  logic [31:0]       w_wrep;
  logic [31:0]       w_word;
  logic [31:0]       w_load;
  logic [IDX_W-1:0]  w_idx;

  assign w_accept    = (r_state == ST_IDLE) && req_i;
  assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_idx       = r_addr[IDX_W+1:2];
  assign w_word      = r_mem[w_idx];
  assign w_commit    = w_last_wait && r_we && !w_err;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;

  // DEPTH_WORDS is a power of two, so any set bit above the index field
  // means the word index is out of range.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_oob
      assign w_oob = |r_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  always_comb begin
    w_err = 1'b0;
    case (r_size)
      SZ_BYTE: w_err = w_oob;
      SZ_HALF: w_err = r_addr[0] | w_oob;
      SZ_WORD: w_err = (|r_addr[1:0]) | w_oob;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be   = '0;
    w_wrep = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wrep = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_wdata[15:0]}};
      end
      SZ_WORD: w_be = '1;
      default: w_be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ready_o  = 1'b0;
    rvalid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (req_i) w_next = ST_WAIT;
      end
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: begin
        rvalid_o = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_cnt      <= CNT_LOAD;
      r_addr     <= addr_i;
      r_we       <= we_i;
      r_size     <= size_i;
      r_unsigned <= unsigned_i;
      r_wdata    <= wdata_i;
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result is latched on the last WAIT edge so it is visible during RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_last_wait) begin
      r_rdata <= (w_err || r_we) ? '0 : w_load;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[IDX_W'(i)] <= '0;
    end else if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  dmem_load_align u_align (
    .i_word     (w_word),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (LATENCY=2, DEPTH_WORDS=64) against a
// byte-array reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mem [DEPTH*4];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) m_mem[i] = 8'h00;
  endfunction

  // Byte-addressed model: a legal access touches nb consecutive bytes.
  function automatic void model_access(input logic we, input logic [1:0] size,
                                       input logic uns, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
    int unsigned nb;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
         (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(DEPTH*4));
    rd = '0;
    if (er) return;
    if (we) begin
      for (int unsigned i = 0; i < nb; i++) m_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int unsigned i = 0; i < nb; i++) v = v | (32'(m_mem[addr + i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd = v;
    end
  endfunction

  // Issues one access starting at a negedge and observes cycles 1..LAT+4.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er,
                           output int rv_cyc, output int rdy_cyc,
                           output int pulses, output logic [31:0] rd_hold);
    int guard = 0;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
    addr_i = addr; wdata_i = wdata;
    @(negedge clk);
    req_i = 1'b0;
    we_i = 1'($urandom); size_i = 2'($urandom); unsigned_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    rd = '0; er = 1'b0; rv_cyc = -1; rdy_cyc = -1; pulses = 0; rd_hold = '0;
    for (int k = 1; k <= LAT + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (rvalid_o) begin
        pulses++;
        if (rv_cyc < 0) begin
          rv_cyc = k; rd = rdata_o; er = err_o;
        end
      end
      if (ready_o && rdy_cyc < 0) rdy_cyc = k;
      if (k == LAT + 2) rd_hold = rdata_o;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 1'b1; we_i = 1'b1; size_i = SZ_WORD; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_checks++; if (rvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
    n_checks++; if (rdata_o !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    rst_n = 1'b1; req_i = 1'b0;
    model_clear();
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      n_checks++; if (rvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_no_accept: got %b want 0", rvalid_o); end
    end
  endtask

  task automatic test_store_load_word();
    logic [31:0] rd, hold, e; logic er, ee; int rv, rdy, p;
    model_access(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, e, ee);
    do_access(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL sw_result: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    n_checks++; if (rv !== LAT + 1) begin n_errors++; $display("FAIL sw_rvalid_cycle: got %0d want %0d", rv, LAT + 1); end
    model_access(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, e, ee);
    do_access(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL lw_err: got %b want 0", er); end
    n_checks++; if (rv !== 3) begin n_errors++; $display("FAIL lw_rvalid_cycle: got %0d want 3", rv); end
    n_checks++; if (rdy !== 4) begin n_errors++; $display("FAIL lw_ready_cycle: got %0d want 4", rdy); end
    n_checks++; if (p !== 1) begin n_errors++; $display("FAIL lw_pulses: got %0d want 1", p); end
  endtask

  task automatic test_subword();
    logic [31:0] rd, hold, e; logic er, ee; int rv, rdy, p;
    model_access(1'b1, SZ_BYTE, 1'b0, 32'h09, 32'hFFFF_FF80, e, ee);
    do_access(1'b1, SZ_BYTE, 1'b0, 32'h09, 32'hFFFF_FF80, rd, er, rv, rdy, p, hold);
    do_access(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'hDEAD80EF) begin n_errors++; $display("FAIL sb_merge: got %h want dead80ef", rd); end
    do_access(1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
    do_access(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'h00000080) begin n_errors++; $display("FAIL lbu: got %h want 00000080", rd); end
    do_access(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'hFFFFDEAD) begin n_errors++; $display("FAIL lh_signed: got %h want ffffdead", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, hold, e; logic er, ee; int rv, rdy, p;
    do_access(1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL err_lh_misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    n_checks++; if (rv !== LAT + 1 || rdy !== LAT + 2) begin n_errors++; $display("FAIL err_timing: got rv=%0d rdy=%0d want %0d %0d", rv, rdy, LAT + 1, LAT + 2); end
    model_access(1'b1, SZ_WORD, 1'b0, 32'h02, 32'h11111111, e, ee);
    do_access(1'b1, SZ_WORD, 1'b0, 32'h02, 32'h11111111, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL err_sw_misaligned: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    do_access(1'b1, 2'b11, 1'b0, 32'h00, 32'h22222222, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL err_size11: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    do_access(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL err_word0_unchanged: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    do_access(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL err_oob: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, hold; logic er; int rv, rdy, p;
    int pulses = 0;
    int guard = 0;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_i = 1'b1; we_i = 1'b1; size_i = SZ_WORD; addr_i = 32'h10; wdata_i = 32'h12345678;
    @(negedge clk);
    // Cycle 1 (WAIT): reset asserted, with a second store presented meanwhile.
    rst_n = 1'b0; req_i = 1'b1; addr_i = 32'h14; wdata_i = 32'hCAFEF00D;
    if (rvalid_o) pulses++;
    @(negedge clk);
    rst_n = 1'b1; req_i = 1'b0;
    model_clear();
    for (int k = 0; k < LAT + 4; k++) begin
      if (rvalid_o) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL abort_no_rvalid: got %0d pulses want 0", pulses); end
    n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL abort_ready: got %b want 1", ready_o); end
    do_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_errors++; $display("FAIL abort_no_write: got rdata=%h err=%b want 0 0", rd, er); end
    do_access(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, rd, er, rv, rdy, p, hold);
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL req_in_reset: got rdata=%h want 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, hold, e, addr, wd; logic er, ee, we, uns; logic [1:0] sz;
    int rv, rdy, p;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 15));
      wd   = $urandom;
      model_access(we, sz, uns, addr, wd, e, ee);
      do_access(we, sz, uns, addr, wd, rd, er, rv, rdy, p, hold);
      n_checks++; if (rd !== e) begin n_errors++; $display("FAIL rand_rdata: we=%b sz=%0d addr=%h got %h want %h", we, sz, addr, rd, e); end
      n_checks++; if (er !== ee) begin n_errors++; $display("FAIL rand_err: we=%b sz=%0d addr=%h got %b want %b", we, sz, addr, er, ee); end
      n_checks++; if (rv !== LAT + 1 || rdy !== LAT + 2) begin n_errors++; $display("FAIL rand_timing: got rv=%0d rdy=%0d want %0d %0d", rv, rdy, LAT + 1, LAT + 2); end
      n_checks++; if (p !== 1) begin n_errors++; $display("FAIL rand_pulses: got %0d want 1", p); end
      n_checks++; if (hold !== e) begin n_errors++; $display("FAIL rand_hold: got %h want %h", hold, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] e, want;
    logic ee;
    int last = -1;
    int accepts = 0;
    int ncyc = 30;
    req_i = 1'b1; we_i = 1'b0; size_i = SZ_WORD; unsigned_i = 1'b0; wdata_i = '0;
    for (int c = 0; c < ncyc + LAT + 3; c++) begin
      if (c == ncyc) req_i = 1'b0;
      if (rvalid_o) begin
        want = (expq.size() > 0) ? expq.pop_front() : 32'hxxxx_xxxx;
        n_checks++; if (rdata_o !== want || err_o !== 1'b0) begin n_errors++; $display("FAIL b2b_data: got %h err=%b want %h err=0", rdata_o, err_o, want); end
      end
      addr_i = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (ready_o && req_i) begin
        model_access(1'b0, SZ_WORD, 1'b0, addr_i, 32'h0, e, ee);
        expq.push_back(e);
        if (last >= 0) begin
          n_checks++; if (c - last !== LAT + 2) begin n_errors++; $display("FAIL b2b_spacing: got %0d want %0d", c - last, LAT + 2); end
        end
        last = c;
        accepts++;
      end
      @(negedge clk);
    end
    n_checks++; if (accepts !== (ncyc - 1) / (LAT + 2) + 1) begin n_errors++; $display("FAIL b2b_accepts: got %0d want %0d", accepts, (ncyc - 1) / (LAT + 2) + 1); end
    n_checks++; if (expq.size() !== 0) begin n_errors++; $display("FAIL b2b_drain: got %0d outstanding want 0", expq.size()); end
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    @(negedge clk);
    test_reset();
    test_store_load_word();
    test_subword();
    test_errors();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit words; power of two, >= 2.
REQ-003 Parameter LATENCY, default 2, wait cycles per access; >= 1.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_i  in  1  access request; accepted when req_i & ready_o at a rising edge.
REQ-007 we_i  in  1  1 = store, 0 = load.
REQ-008 size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 addr_i  in  ADDR_W  byte address.
REQ-011 wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready_o  out  1  high only in IDLE.
REQ-013 rvalid_o  out  1  one-cycle completion pulse, loads and stores.
REQ-014 rdata_o  out  32  load result; 0 for stores and errors.
REQ-015 err_o  out  1  access error; meaningful when rvalid_o = 1.

Function
REQ-016 Three states: IDLE, WAIT, RESP; IDLE -> WAIT on accept; WAIT -> RESP when wait counter = 0; RESP -> IDLE unconditionally.
REQ-017 On accept, addr_i, we_i, size_i, unsigned_i, wdata_i are captured; later input changes have no effect on that access.
REQ-018 WAIT lasts exactly LATENCY cycles: accept sampled at the edge ending cycle 0, WAIT in cycles 1..LATENCY, rvalid_o high in cycle LATENCY+1, ready_o high again in cycle LATENCY+2.
REQ-019 req_i while ready_o = 0 is ignored; no queuing.
REQ-020 Memory is little-endian; word index = addr[ADDR_W-1:2], byte lane = addr[1:0].
REQ-021 Store byte writes lane addr[1:0] only; store half writes lanes {addr[1],0} and {addr[1],1}; store word writes all four lanes; other lanes are unchanged.
REQ-022 Store commits at the edge ending cycle LATENCY; a load issued afterwards returns the new data.
REQ-023 Load extracts the addressed byte or half, then sign- or zero-extends it to 32 bits per unsigned_i; unsigned_i is ignored for word loads.
REQ-024 Error when: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; word index >= DEPTH_WORDS.
REQ-025 On error, no lane is written, rdata_o = 0, err_o = 1; timing is identical to a legal access.
REQ-026 rdata_o and err_o update only in the RESP cycle and hold until the next RESP cycle.

Reset
REQ-027 rst_n low at a rising edge forces IDLE, wait counter 0, ready_o 1, rvalid_o 0, rdata_o 0, err_o 0, all memory words 0.
REQ-028 Reset during WAIT or RESP abandons the access: no write, no rvalid_o pulse.
REQ-029 Any request presented while rst_n is low is not accepted.

Structure
REQ-030 Package dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-031 Load lane extraction and extension is a combinational sub-module, dmem_load_align; all other logic resides in dmem_ctrl.
REQ-032 Memory array is DEPTH_WORDS x 32 with per-byte write enables; no vendor macros.

Verification (LATENCY=2, DEPTH_WORDS=64)
REQ-033 Store word 0xDEADBEEF @0x08, then load word @0x08 -> rvalid_o in cycle 3 after accept, rdata_o=0xDEADBEEF, err_o=0; ready_o high in cycle 4.
REQ-034 Store byte 0x80 @0x09 onto word 0xDEADBEEF -> word reads 0xDEAD80EF; load byte signed @0x09 -> 0xFFFFFF80; unsigned -> 0x00000080; load half signed @0x0A -> 0xFFFFDEAD.
REQ-035 Load half @0x03, store word 0x11111111 @0x02, size 11 @0x00 -> each gives err_o=1, rdata_o=0, normal timing; word @0x00 unchanged.
REQ-036 Load word @0x100 (index 64) -> err_o=1, rdata_o=0.
REQ-037 Store word 0x12345678 @0x10 with rst_n low during cycle 1 -> no rvalid_o pulse; load word @0x10 afterwards -> 0x00000000.
REQ-038 req_i held high with changing addr_i -> exactly one accept per LATENCY+2 cycles, each using the addr_i sampled when ready_o was high.
